// File: rtl/natural_log_arbiter.sv
// Round-robin arbiter that shares one pipelined natural-log unit among NUM_REQ requesters.
// Optional feature macro NATURAL_LOG_ARB_CLAMP_EN: operands below 1.0 are answered with 0 without using the log unit.
module natural_log_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int LOG_LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [24*NUM_REQ-1:0]  req_data,
  output logic [23:0]            log_in_8_shifted,
  output logic                   log_in_valid,
  input  logic [15:0]            log_out_8_shifted,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [15:0]            resp_data,
  output logic [NUM_REQ-1:0]     busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                   r_arm;
  logic [IW-1:0]          r_ptr;
  logic [NUM_REQ-1:0]     r_busy;
  logic [LOG_LATENCY-1:0] r_tag_v;
  logic [LOG_LATENCY-1:0] r_tag_clamp;
  logic [IW-1:0]          r_tag_idx [LOG_LATENCY];
  logic [NUM_REQ-1:0]     r_resp_valid;
  logic [15:0]            r_resp_data;

  logic [NUM_REQ-1:0]     w_elig;
  logic [NUM_REQ-1:0]     w_gnt_oh;
  logic [NUM_REQ-1:0]     w_exit_oh;
  logic                   w_gnt;
  logic [IW-1:0]          w_gnt_idx;
  logic [IW:0]            w_sum;
  logic [IW:0]            w_idx;
  logic                   w_hit;
  logic [23:0]            w_opnd;
  logic                   w_clamp;

  // Round-robin search starting at the pointer; scanning from the far end lets the nearest hit win.
  always_comb begin
    w_elig    = req_valid & ~r_busy & {NUM_REQ{r_arm}};
    w_gnt     = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    w_idx     = '0;
    w_hit     = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum     = {1'b0, r_ptr} + (IW+1)'(k);
      w_idx     = (w_sum >= (IW+1)'(NUM_REQ)) ? (w_sum - (IW+1)'(NUM_REQ)) : w_sum;
      w_hit     = w_elig[w_idx[IW-1:0]];
      w_gnt     = w_gnt | w_hit;
      w_gnt_idx = w_hit ? w_idx[IW-1:0] : w_gnt_idx;
    end
  end

  assign w_opnd = req_data[w_gnt_idx * 24 +: 24];

`ifdef NATURAL_LOG_ARB_CLAMP_EN
  assign w_clamp = w_gnt & (w_opnd < 24'd256);
`else
  assign w_clamp = 1'b0;
`endif

  // One-hot decode of the grant and of the tag leaving the pipeline.
  always_comb begin
    w_gnt_oh  = '0;
    w_exit_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gnt_oh[i]  = w_gnt & (w_gnt_idx == IW'(i));
      w_exit_oh[i] = r_tag_v[LOG_LATENCY-1] & (r_tag_idx[LOG_LATENCY-1] == IW'(i));
    end
  end

  assign req_ready        = w_gnt_oh;
  assign log_in_valid     = w_gnt & ~w_clamp;
  assign log_in_8_shifted = log_in_valid ? w_opnd : 24'd0;

  // Issue bookkeeping: r_arm blocks issue in the first clock after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arm  <= 1'b0;
      r_ptr  <= '0;
      r_busy <= '0;
    end else begin
      r_arm <= 1'b1;
      if (w_gnt) begin
        r_ptr <= (w_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : (w_gnt_idx + IW'(1));
      end
      r_busy <= (r_busy | w_gnt_oh) & ~r_resp_valid;
    end
  end

  // Tag pipeline aligned with the log unit latency; clamped entries travel as valid tags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_v     <= '0;
      r_tag_clamp <= '0;
      for (int i = 0; i < LOG_LATENCY; i++) begin
        r_tag_idx[i] <= '0;
      end
    end else begin
      r_tag_v[0]     <= w_gnt;
      r_tag_clamp[0] <= w_clamp;
      r_tag_idx[0]   <= w_gnt_idx;
      for (int i = 1; i < LOG_LATENCY; i++) begin
        r_tag_v[i]     <= r_tag_v[i-1];
        r_tag_clamp[i] <= r_tag_clamp[i-1];
        r_tag_idx[i]   <= r_tag_idx[i-1];
      end
    end
  end

  // Result capture when a valid tag exits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_valid <= '0;
      r_resp_data  <= 16'd0;
    end else begin
      r_resp_valid <= w_exit_oh;
      if (r_tag_v[LOG_LATENCY-1]) begin
        r_resp_data <= r_tag_clamp[LOG_LATENCY-1] ? 16'd0 : log_out_8_shifted;
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign busy       = r_busy;

endmodule

// File: tb/tb_natural_log_arbiter.sv
// Randomized + directed bench for natural_log_arbiter against a cycle-indexed reference model.
// Honours NATURAL_LOG_ARB_CLAMP_EN in the model when the design is built with it.
module tb_natural_log_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int LOG_LATENCY = 3;

`ifdef NATURAL_LOG_ARB_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [24*NUM_REQ-1:0] req_data;
  logic [23:0]           log_in_8_shifted;
  logic                  log_in_valid;
  logic [15:0]           log_out_8_shifted;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [15:0]           resp_data;
  logic [NUM_REQ-1:0]    busy;

  natural_log_arbiter #(.NUM_REQ(NUM_REQ), .LOG_LATENCY(LOG_LATENCY)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .log_in_8_shifted(log_in_8_shifted), .log_in_valid(log_in_valid),
    .log_out_8_shifted(log_out_8_shifted),
    .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural natural-log unit: ln(x/256)*256 rounded, 0 for operands below 1.0.
  function automatic logic [15:0] ln_ref(input logic [23:0] x);
    real r;
    if (x < 24'd256) return 16'd0;
    r = $ln(real'(x) / 256.0) * 256.0 + 0.5;
    return 16'($rtoi(r));
  endfunction

  logic [15:0] lu_pipe [LOG_LATENCY];
  always @(posedge clk) begin
    lu_pipe[0] <= log_in_valid ? ln_ref(log_in_8_shifted) : 16'hBEEF;
    for (int k = 1; k < LOG_LATENCY; k++) lu_pipe[k] <= lu_pipe[k-1];
  end
  assign log_out_8_shifted = lu_pipe[LOG_LATENCY-1];

  typedef struct { int cyc; int idx; logic [15:0] data; } resp_t;
  resp_t       m_q[$];
  int          m_gnt [NUM_REQ];
  int          m_ptr;
  logic [15:0] m_rdata;
  bit          m_armed;
  int          cyc;
  int          n_checks;
  int          n_fail;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    for (int i = 0; i < NUM_REQ; i++) m_gnt[i] = -1000;
    m_ptr   = 0;
    m_rdata = 16'd0;
  endtask

  // One clock: drive inputs after the edge, then check every output half a period later.
  task automatic run_cycle(input bit rst_lo, input logic [NUM_REQ-1:0] v, input logic [24*NUM_REQ-1:0] d);
    logic [NUM_REQ-1:0] busy_m, elig, exp_rdy, exp_rv;
    logic [23:0] opnd;
    bit clamp, exp_liv;
    int g;
    @(posedge clk);
    m_armed = (reset_n === 1'b1);
    #1;
    reset_n   = !rst_lo;
    req_valid = v;
    req_data  = d;
    if (rst_lo) begin
      model_clear();
      m_armed = 1'b0;
    end
    cyc++;
    @(negedge clk);
    busy_m = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (cyc >= m_gnt[i] + 1 && cyc <= m_gnt[i] + LOG_LATENCY + 1) busy_m[i] = 1'b1;
    elig = m_armed ? (v & ~busy_m) : '0;
    g = -1;
    for (int k = 0; k < NUM_REQ; k++)
      if (g < 0 && elig[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
    exp_rdy = '0;
    opnd    = 24'd0;
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      opnd = d[24*g +: 24];
    end
    clamp   = CLAMP && (g >= 0) && (opnd < 24'd256);
    exp_liv = (g >= 0) && !clamp;
    exp_rv  = '0;
    if (m_q.size() > 0 && m_q[0].cyc == cyc) begin
      exp_rv[m_q[0].idx] = 1'b1;
      m_rdata = m_q[0].data;
      void'(m_q.pop_front());
    end
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_eq("log_in_valid", 32'(log_in_valid), 32'(exp_liv));
    check_eq("log_in_8_shifted", 32'(log_in_8_shifted), exp_liv ? 32'(opnd) : 32'd0);
    check_eq("busy", 32'(busy), 32'(busy_m));
    check_eq("resp_valid", 32'(resp_valid), 32'(exp_rv));
    check_eq("resp_data", 32'(resp_data), 32'(m_rdata));
    if (g >= 0) begin
      m_gnt[g] = cyc;
      m_ptr    = (g + 1) % NUM_REQ;
      m_q.push_back('{cyc: cyc + LOG_LATENCY + 1, idx: g, data: clamp ? 16'd0 : ln_ref(opnd)});
    end
  endtask

  function automatic logic [24*NUM_REQ-1:0] pack(input logic [23:0] a, input logic [23:0] b,
                                                  input logic [23:0] c, input logic [23:0] e);
    return {e, c, b, a};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, '0, '0);
  endtask

  task automatic do_reset();
    run_cycle(1'b1, '0, '0);
    run_cycle(1'b1, '0, '0);
  endtask

  logic [24*NUM_REQ-1:0] rd;
  logic [NUM_REQ-1:0]    rv;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    model_clear();

    // Single request of 10.0 right at reset release.
    do_reset();
    run_cycle(1'b0, 4'b0001, pack(24'h000A00, 24'h0, 24'h0, 24'h0));
    run_cycle(1'b0, 4'b0001, pack(24'h000A00, 24'h0, 24'h0, 24'h0));
    idle(6);

    // All four request together from a fresh pointer.
    do_reset();
    run_cycle(1'b0, 4'b0000, '0);
    for (int i = 0; i < 4; i++)
      run_cycle(1'b0, 4'b1111, pack(24'h000200, 24'h001000, 24'h00FF00, 24'h123456));
    idle(6);

    // Requester 2 holds its request continuously.
    for (int i = 0; i < 14; i++)
      run_cycle(1'b0, 4'b0100, pack(24'h0, 24'h0, 24'h000300 + 24'(i), 24'h0));
    idle(2);

    // Reset while three operations are in flight.
    for (int i = 0; i < 3; i++)
      run_cycle(1'b0, 4'b1111, pack(24'h000400, 24'h000500, 24'h000600, 24'h000700));
    do_reset();
    run_cycle(1'b0, 4'b1111, pack(24'h000400, 24'h000500, 24'h000600, 24'h000700));
    run_cycle(1'b0, 4'b1111, pack(24'h000400, 24'h000500, 24'h000600, 24'h000700));
    idle(8);

    // Operand below 1.0 (clamped or forwarded depending on build).
    run_cycle(1'b0, 4'b0001, pack(24'h000080, 24'h0, 24'h0, 24'h0));
    idle(6);

    // Requester 1 withdraws while 3 wins the round-robin.
    do_reset();
    run_cycle(1'b0, 4'b0000, '0);
    run_cycle(1'b0, 4'b0100, pack(24'h0, 24'h0, 24'h000900, 24'h0));
    run_cycle(1'b0, 4'b1010, pack(24'h0, 24'h000A00, 24'h0, 24'h000B00));
    idle(6);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      rv = 4'($urandom_range(0, 15));
      for (int i = 0; i < NUM_REQ; i++)
        rd[24*i +: 24] = ($urandom_range(0, 3) == 0) ? 24'($urandom_range(0, 255)) : 24'($urandom);
      run_cycle($urandom_range(0, 149) == 0, rv, rd);
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
